// File: rtl/mem_access_unit.sv
// Load/store unit: core request in, word-aligned bus access out.
// Ports: core req/rsp handshake, stall (busy), single-beat bus master.
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [2:0]      req_type,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            busy,
  output logic            bus_valid,
  input  logic            bus_ready,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_be,
  input  logic [XLEN-1:0] bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam int CW = $clog2(TIMEOUT + 2);

  logic [1:0]      state_q, state_d;
  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      type_q;
  logic            err_q, err_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            in_bus;
  logic            in_resp;
  logic            accept;
  logic            illegal;
  logic            misal;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [XLEN-1:0] ld_data;
  logic [3:0]      be;
  logic [XLEN-1:0] wrep;

  assign in_bus  = (state_q == S_BUS);
  assign in_resp = (state_q == S_RESP);
  assign accept  = req_valid & req_ready;

  assign req_ready = (state_q == S_IDLE);
  assign busy      = ~req_ready;

  always_comb begin
    illegal = 1'b0;
    misal   = 1'b0;
    unique case (req_type)
      3'b000: illegal = 1'b0;
      3'b001: misal   = req_addr[0];
      3'b010: misal   = |req_addr[1:0];
      3'b100: illegal = req_we;
      3'b101: begin
        illegal = req_we;
        misal   = req_addr[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  // Lane pick from the raw bus word using the byte offset.
  assign ld_b = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign ld_h = bus_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    unique case (type_q)
      3'b000:  ld_data = {{(XLEN-8){ld_b[7]}}, ld_b};
      3'b001:  ld_data = {{(XLEN-16){ld_h[15]}}, ld_h};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_b};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_h};
      default: ld_data = bus_rdata;
    endcase
  end

  always_comb begin
    unique case (type_q[1:0])
      2'b00: begin
        be   = 4'b0001 << addr_q[1:0];
        wrep = {(XLEN/8){wdata_q[7:0]}};
      end
      2'b01: begin
        be   = 4'b0011 << addr_q[1:0];
        wrep = {(XLEN/16){wdata_q[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wrep = wdata_q;
      end
    endcase
  end

  // Bus outputs are zero outside BUS; registers hold them steady inside.
  assign bus_valid = in_bus;
  assign bus_we    = in_bus & we_q;
  assign bus_addr  = in_bus ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign bus_be    = in_bus ? be : 4'b0000;
  assign bus_wdata = in_bus ? wrep : '0;

  assign rsp_valid = in_resp;
  assign rsp_err   = in_resp & err_q;
  assign rsp_rdata = in_resp ? rdata_q : '0;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = (illegal | misal) ? S_RESP : S_BUS;
          err_d   = illegal | misal;
          rdata_d = '0;
          cnt_d   = '0;
        end
      end
      S_BUS: begin
        // A completion on the timeout cycle wins over the error.
        if (bus_ready) begin
          state_d = S_RESP;
          rdata_d = we_q ? '0 : ld_data;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      type_q  <= 3'b000;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      type_q  <= req_type;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit.
// Checks bus/rsp behaviour against an arithmetic reference model.
module tb_mem_access_unit;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_type = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        bus_valid;
  logic        bus_ready = 1'b0;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata = '0;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_type(req_type),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int m_size(input logic [2:0] t);
    return 1 << t[1:0];
  endfunction

  function automatic bit m_err(input bit we, input logic [2:0] t,
                               input logic [31:0] a);
    bit legal;
    legal = (t <= 3'd2) || ((t == 3'd4 || t == 3'd5) && !we);
    if (!legal) return 1'b1;
    return (a % 32'(m_size(t))) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] t,
                                      input logic [31:0] a);
    int n;
    n = m_size(t);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] t,
                                          input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = m_size(t);
    r = '0;
    for (int k = 0; k < 4; k++)
      r[8*k +: 8] = wd[8*(k % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rdata(input bit we,
                                          input logic [2:0] t,
                                          input logic [31:0] a,
                                          input logic [31:0] rd);
    longint v;
    int n;
    if (we) return 32'h0;
    n = m_size(t);
    v = longint'(rd >> (8 * (a % 4)));
    if (n < 4) begin
      v = v % (longint'(1) << (8 * n));
      if (t[2] == 1'b0 && v >= (longint'(1) << (8 * n - 1)))
        v = v - (longint'(1) << (8 * n));
    end
    return 32'(v);
  endfunction

  task automatic txn(input bit we, input logic [2:0] t,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input int waitn);
    bit e;
    bit to;
    @(negedge clk);
    chk("ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_we    = we;
    req_type  = t;
    req_addr  = a;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_type  = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    e = m_err(we, t, a);
    if (e) begin
      chk("err_rsp_valid", rsp_valid, 1'b1);
      chk("err_rsp_err", rsp_err, 1'b1);
      chk("err_rsp_rdata", rsp_rdata, 32'h0);
      chk("err_no_bus", bus_valid, 1'b0);
      chk("err_busy", busy, 1'b1);
    end else begin
      to = (waitn > TO);
      for (int i = 0; i <= TO; i++) begin
        chk("bus_valid", bus_valid, 1'b1);
        chk("bus_we", bus_we, we);
        chk("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
        chk("bus_be", bus_be, m_be(t, a));
        if (we) chk("bus_wdata", bus_wdata, m_wdata(t, wd));
        chk("bus_rsp_low", rsp_valid, 1'b0);
        chk("bus_busy", busy, 1'b1);
        bus_ready = (i == waitn);
        bus_rdata = (i == waitn) ? rd : $urandom;
        @(negedge clk);
        if (i == waitn || i == TO) break;
      end
      bus_ready = 1'($urandom);
      bus_rdata = $urandom;
      chk("rsp_valid", rsp_valid, 1'b1);
      chk("rsp_err", rsp_err, to);
      chk("rsp_rdata", rsp_rdata, to ? 32'h0 : m_rdata(we, t, a, rd));
      chk("rsp_bus_low", bus_valid, 1'b0);
    end
    @(negedge clk);
    bus_ready = 1'b0;
    chk("rsp_one_cycle", rsp_valid, 1'b0);
    chk("back_idle", req_ready, 1'b1);
  endtask

  initial begin
    int acc;
    int rsp;
    int out;
    int wn;

    @(negedge clk);
    chk("rst_bus_valid", bus_valid, 1'b0);
    chk("rst_bus_we", bus_we, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_bus_be", bus_be, 4'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);

    txn(1'b0, 3'b000, 32'h0000_1002, 32'h0, 32'h0080_0000, 0);
    txn(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'hDEAD_BEEF, 0);
    txn(1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 0);
    txn(1'b0, 3'b101, 32'h0000_0000, 32'h0, 32'h0000_8001, TO + 1);
    txn(1'b0, 3'b101, 32'h0000_0000, 32'h0, 32'h0000_8001, TO);
    txn(1'b1, 3'b100, 32'h0000_0000, 32'h0, 32'h0, 0);
    txn(1'b0, 3'b111, 32'h0000_0010, 32'h0, 32'h0, 0);

    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_type  = 3'b010;
    req_addr  = 32'h0000_0040;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_bus_valid", bus_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("abort_bus_valid", bus_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rsp", rsp_valid, 1'b0);
    chk("abort_addr", bus_addr, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 1'b0);
      chk("abort_ready", req_ready, 1'b1);
    end

    req_valid = 1'b1;
    req_we    = 1'b0;
    req_type  = 3'b010;
    req_addr  = 32'h0000_0100;
    bus_ready = 1'b1;
    bus_rdata = 32'h5555_AAAA;
    acc = 0;
    rsp = 0;
    for (int c = 0; c < 21; c++) begin
      out = acc - rsp;
      if (req_ready) chk("b2b_outstanding", 32'(out), 32'h0);
      if (req_ready) acc++;
      if (rsp_valid) rsp++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    bus_ready = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd7);
    chk("b2b_resps", 32'(rsp), 32'd7);
    repeat (3) @(negedge clk);

    for (int n = 0; n < 300; n++) begin
      wn = ($urandom_range(0, 9) == 0) ?
           int'($urandom_range(TO - 1, TO + 2)) :
           int'($urandom_range(0, 3));
      txn(1'($urandom), 3'($urandom), $urandom,
          $urandom, $urandom, wn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
